// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that feeds one UARTTx instance one byte at a time.
// Build option: define UART_ARB_CRLF_EN to append 0x0D 0x0A after the last byte of every packet.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned GW = $clog2(NUM_REQ)
) (
  input  logic                 sourceClk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_byte_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [GW-1:0]        grant_id_o,
  output logic                 busy_o,
  output logic                 uart_cs_o,
  output logic                 uart_tx_en_n_o,
  output logic [7:0]           uart_tx_byte_o,
  input  logic                 uart_tx_complete_i
);

  localparam logic [2:0] StStartup = 3'd0;
  localparam logic [2:0] StArb     = 3'd1;
  localparam logic [2:0] StIssue   = 3'd2;
  localparam logic [2:0] StWait    = 3'd3;
`ifdef UART_ARB_CRLF_EN
  localparam logic [2:0] StSuffix  = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic          cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic          last_q, last_d;
  logic [7:0]    byte_q, byte_d;
`ifdef UART_ARB_CRLF_EN
  logic          sfx_q, sfx_d;  // byte in flight is a suffix byte, not requester data
  logic          lf_q, lf_d;    // suffix byte in flight is 0x0A
`endif

  logic          cand_found;
  logic [GW-1:0] cand_idx;

  // A locked grant only re-offers the owner; otherwise search upward from rr+1 with wrap.
  always_comb begin
    logic [GW-1:0] idx;
    idx        = '0;
    cand_found = 1'b0;
    cand_idx   = grant_q;
    if (lock_q) begin
      cand_found = req_valid_i[grant_q];
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        idx = GW'((32'(rr_q) + k) % NUM_REQ);
        if (!cand_found && req_valid_i[idx]) begin
          cand_found = 1'b1;
          cand_idx   = idx;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    last_d  = last_q;
    byte_d  = byte_q;
`ifdef UART_ARB_CRLF_EN
    sfx_d   = sfx_q;
    lf_d    = lf_q;
`endif
    case (state_q)
      StStartup: begin
        cnt_d = 1'b1;
        if (cnt_q) state_d = StArb;
      end
      StArb: begin
        if (cand_found) begin
          byte_d  = req_byte_i[8*cand_idx +: 8];
          last_d  = req_last_i[cand_idx];
          grant_d = cand_idx;
          lock_d  = ~req_last_i[cand_idx];
          rr_d    = cand_idx;
          state_d = StIssue;
`ifdef UART_ARB_CRLF_EN
          sfx_d   = 1'b0;
`endif
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (uart_tx_complete_i) begin
`ifdef UART_ARB_CRLF_EN
          if (sfx_q) begin
            if (lf_q) begin
              lock_d  = 1'b0;
              sfx_d   = 1'b0;
              state_d = StArb;
            end else begin
              lf_d    = 1'b1;
              state_d = StSuffix;
            end
          end else if (last_q) begin
            lf_d    = 1'b0;
            state_d = StSuffix;
          end else begin
            state_d = StArb;
          end
`else
          if (last_q) lock_d = 1'b0;
          state_d = StArb;
`endif
        end
      end
`ifdef UART_ARB_CRLF_EN
      StSuffix: begin
        byte_d  = lf_q ? 8'h0A : 8'h0D;
        sfx_d   = 1'b1;
        state_d = StIssue;
      end
`endif
      default: state_d = StStartup;
    endcase
  end

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      state_q <= StStartup;
      cnt_q   <= 1'b0;
      lock_q  <= 1'b0;
      rr_q    <= '0;
      grant_q <= '0;
      last_q  <= 1'b0;
      byte_q  <= '0;
`ifdef UART_ARB_CRLF_EN
      sfx_q   <= 1'b0;
      lf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
`ifdef UART_ARB_CRLF_EN
      sfx_q   <= sfx_d;
      lf_q    <= lf_d;
`endif
    end
  end

  always_comb begin
    req_ready_o = '0;
`ifdef UART_ARB_CRLF_EN
    if (state_q == StIssue && !sfx_q) req_ready_o[grant_q] = 1'b1;
`else
    if (state_q == StIssue) req_ready_o[grant_q] = 1'b1;
`endif
  end

  assign grant_id_o     = grant_q;
  assign busy_o         = (state_q != StArb) && (state_q != StStartup);
`ifdef UART_ARB_CRLF_EN
  assign uart_cs_o      = (state_q == StIssue) || (state_q == StWait) || (state_q == StSuffix);
`else
  assign uart_cs_o      = (state_q == StIssue) || (state_q == StWait);
`endif
  assign uart_tx_en_n_o = (state_q != StIssue);
  assign uart_tx_byte_o = byte_q;

endmodule
